arrow_lane_ctrl: RTL and testbench
==================================

Name: arrow_lane_ctrl

Overview:
Per-lane controller for the scrolling-arrow gameplay. It owns a small pool of arrow slots, spawns arrows on request, advances them once per video frame, and judges player hits against the border hit zone at BORDER_Y. Slot positions feed the arrow/border renderers. Hit, miss and score feed the scoring/HUD logic.

Parameters:
NSLOT, 4, number of arrow slots per lane
SPAWN_Y, 0, y written into a newly spawned slot
BORDER_Y, 350, hit-zone centre row, shared with the border renderer
WIN, 10, hit tolerance; the window is BORDER_Y-WIN..BORDER_Y+WIN inclusive
SPEED, 2, pixels advanced per frame_tick

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; starts a game from IDLE
pause  in  1  level; freezes the lane
frame_tick  in  1  one-cycle pulse per frame
spawn_req  in  1  level; held until spawn_ack
spawn_ack  out  1  one-cycle pulse; spawn accepted
hit_req  in  1  one-cycle pulse; player gesture for this lane
hit  out  1  one-cycle pulse; successful hit
miss  out  1  one-cycle pulse; arrow escaped or empty press
busy  out  1  high while in UPDATE
slot_valid  out  NSLOT  per-slot occupancy
slot_y  out  NSLOT*10  packed slot y, slot i at bits [10i+9:10i]
score  out  16  hit count, saturating at 0xFFFF
state  out  2  IDLE=0, RUN=1, UPDATE=2, PAUSE=3

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. All slot_valid=0, slot_y=0, score=0. spawn_ack, hit, miss and busy are 0. The pending-hit flag is cleared.
- All outputs are registered. Pulses appear the cycle after the triggering input edge.
- IDLE:
  - Slots are held empty.
  - start=1 -> score cleared, go to RUN.
  - All other inputs are ignored.
  - start in any other state is ignored.
- RUN, processed in this priority order within one cycle:
  1. Hit judgement, on hit_req or a pending hit. Candidates are valid slots with BORDER_Y-WIN <= y <= BORDER_Y+WIN. Pick the largest y; ties go to the lowest index. Clear that slot, pulse hit, and increment score with saturation. With no candidate, pulse miss (empty press). The pending flag is cleared.
  2. Spawn, on spawn_req. Use the lowest-index slot that was free before this cycle's hit clear. Set y=SPAWN_Y, valid=1, and pulse spawn_ack. If no slot is free, there is no ack and the request stays pending.
  3. frame_tick -> UPDATE with idx=0.
  4. Else if pause=1 -> PAUSE.
- UPDATE:
  - busy=1. Exactly one slot is processed per cycle, idx 0..NSLOT-1, so latency is NSLOT cycles. It then returns to RUN.
  - For a valid slot, compute y+SPEED at 11 bits. If the result > BORDER_Y+WIN, clear the slot and pulse miss. Otherwise store the low 10 bits.
  - Invalid slots are untouched.
  - hit_req here sets a one-deep pending flag; a second hit_req is dropped.
  - spawn_req waits.
  - frame_tick is ignored.
  - pause is honoured only on return to RUN.
- PAUSE:
  - Slots and score are frozen.
  - hit_req, spawn_req and frame_tick are ignored and not latched.
  - A pending flag set before PAUSE is kept.
  - pause=0 -> RUN.
- Width rule: because a slot is cleared once y exceeds BORDER_Y+WIN (360 at defaults), y never wraps. Integration must keep BORDER_Y+WIN+SPEED < 1024.
- Reset mid-UPDATE or mid-PAUSE returns to IDLE with everything cleared. No pulses are emitted during the reset cycle.
- hit and miss are never both high in one cycle.

Decomposition:
- Shared package: state encoding, Y_W=10, SCORE_W=16, BORDER_Y default, and the slot_y packing helper.
- The border renderer imports BORDER_Y from the package so the drawn zone and the judged zone cannot diverge.
- One sub-module, slot_pick. It is combinational and, given valid/y vectors and the window bounds, returns the in-window winner index plus found flag and the lowest-free index plus found flag.

Test Plan:
1. Reset then start, spawn_req held 1 -> spawn_ack one cycle later, slot0 valid with y=0, score=0.
2. Single arrow, 170 frame_ticks, then hit_req -> y=340, hit pulses once, slot0 cleared, score=1.
3. Single arrow, no hit -> after 180 ticks y=360 and still valid; the 181st tick sees miss pulse during UPDATE cycle idx=0, slot0 cleared.
4. Arrows at y=342 and y=356, hit_req -> the y=356 slot is cleared. A second hit_req clears y=342 (after one further tick, y=344), score=2. A third hit_req -> miss (empty press).
5. hit_req in the cycle after frame_tick with an arrow at y=350 -> no hit during the 4 UPDATE cycles; hit pulses on the first RUN cycle after UPDATE, busy high for exactly 4 cycles.
6. Fill all 4 slots, hold spawn_req -> no ack. hit_req clears an in-window slot -> ack on the next RUN cycle reusing that index. Then pause=1 -> 10 frame_ticks leave slot_y unchanged. rst=0 mid-PAUSE -> IDLE with all outputs 0.

Source files
------------

// File: rtl/arrow_lane_ctrl_pkg.sv
// Shared definitions for the arrow lane controller and the border renderer.
package arrow_lane_ctrl_pkg;

    localparam int unsigned Y_W      = 10;
    localparam int unsigned SCORE_W  = 16;
    localparam int unsigned BORDER_Y = 350;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UPDATE = 2'd2,
        ST_PAUSE  = 2'd3
    } lane_state_e;

    // Bit offset of slot i inside the packed slot_y bus.
    function automatic int unsigned slot_lo(input int unsigned i);
        return i * Y_W;
    endfunction

endpackage

// File: rtl/arrow_lane_ctrl_slot_pick.sv
// Combinational slot selection: in-window winner (largest y, lowest index on tie) and lowest free slot.
module arrow_lane_ctrl_slot_pick
    import arrow_lane_ctrl_pkg::*;
#(
    parameter int unsigned NSLOT = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NSLOT-1:0]     valid,
    input  logic [NSLOT*Y_W-1:0] y,
    input  logic [Y_W-1:0]       win_lo,
    input  logic [Y_W-1:0]       win_hi,
    output logic [IDX_W-1:0]     win_idx_c,
    output logic                 win_found_c,
    output logic [IDX_W-1:0]     free_idx_c,
    output logic                 free_found_c
);

    logic [Y_W-1:0] best_y;
    logic [Y_W-1:0] cur_y;

    always_comb begin
        win_idx_c    = '0;
        win_found_c  = 1'b0;
        free_idx_c   = '0;
        free_found_c = 1'b0;
        best_y       = '0;
        cur_y        = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            cur_y = y[slot_lo(i) +: Y_W];
            // Strict compare keeps the lowest index on equal y.
            if (valid[i] && (cur_y >= win_lo) && (cur_y <= win_hi) &&
                (!win_found_c || (cur_y > best_y))) begin
                win_found_c = 1'b1;
                win_idx_c   = IDX_W'(i);
                best_y      = cur_y;
            end
            if (!valid[i] && !free_found_c) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/arrow_lane_ctrl.sv
// Per-lane arrow controller: spawns arrows, advances them one slot per cycle on each frame, judges hits.
module arrow_lane_ctrl
    import arrow_lane_ctrl_pkg::*;
#(
    parameter int unsigned NSLOT    = 4,
    parameter int unsigned SPAWN_Y  = 0,
    parameter int unsigned BORDER_Y = arrow_lane_ctrl_pkg::BORDER_Y,
    parameter int unsigned WIN      = 10,
    parameter int unsigned SPEED    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 frame_tick,
    input  logic                 spawn_req,
    output logic                 spawn_ack,
    input  logic                 hit_req,
    output logic                 hit,
    output logic                 miss,
    output logic                 busy,
    output logic [NSLOT-1:0]     slot_valid,
    output logic [NSLOT*Y_W-1:0] slot_y,
    output logic [SCORE_W-1:0]   score,
    output logic [1:0]           state
);

    localparam int unsigned    IDX_W     = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [Y_W-1:0] WIN_LO    = Y_W'(BORDER_Y - WIN);
    localparam logic [Y_W-1:0] WIN_HI    = Y_W'(BORDER_Y + WIN);
    localparam logic [Y_W:0]   ESC_LIM   = (Y_W + 1)'(BORDER_Y + WIN);
    localparam logic [Y_W:0]   STEP      = (Y_W + 1)'(SPEED);
    localparam logic [Y_W-1:0] SPAWN_VAL = Y_W'(SPAWN_Y);

    lane_state_e      st_q;
    logic             pending_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] win_idx_c;
    logic             win_found_c;
    logic [IDX_W-1:0] free_idx_c;
    logic             free_found_c;
    logic [Y_W-1:0]   cur_y_c;
    logic [Y_W:0]     adv_y_c;

    arrow_lane_ctrl_slot_pick #(
        .NSLOT (NSLOT),
        .IDX_W (IDX_W)
    ) u_slot_pick (
        .valid        (slot_valid),
        .y            (slot_y),
        .win_lo       (WIN_LO),
        .win_hi       (WIN_HI),
        .win_idx_c    (win_idx_c),
        .win_found_c  (win_found_c),
        .free_idx_c   (free_idx_c),
        .free_found_c (free_found_c)
    );

    // One extra bit so an escaping arrow is detected before any wrap.
    assign cur_y_c = slot_y[slot_lo(32'(idx_q)) +: Y_W];
    assign adv_y_c = {1'b0, cur_y_c} + STEP;
    assign state   = st_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q       <= ST_IDLE;
            pending_q  <= 1'b0;
            idx_q      <= '0;
            slot_valid <= '0;
            slot_y     <= '0;
            score      <= '0;
            spawn_ack  <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            spawn_ack <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            case (st_q)
                ST_IDLE: begin
                    slot_valid <= '0;
                    if (start) begin
                        score <= '0;
                        st_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hit_req || pending_q) begin
                        pending_q <= 1'b0;
                        if (win_found_c) begin
                            slot_valid[win_idx_c] <= 1'b0;
                            hit <= 1'b1;
                            if (score != '1) score <= score + SCORE_W'(1);
                        end else begin
                            miss <= 1'b1;
                        end
                    end
                    // Free index comes from pre-clear occupancy, so it never collides with the hit slot.
                    if (spawn_req && free_found_c) begin
                        slot_valid[free_idx_c]                   <= 1'b1;
                        slot_y[slot_lo(32'(free_idx_c)) +: Y_W] <= SPAWN_VAL;
                        spawn_ack                                <= 1'b1;
                    end
                    if (frame_tick) begin
                        st_q  <= ST_UPDATE;
                        idx_q <= '0;
                        busy  <= 1'b1;
                    end else if (pause) begin
                        st_q <= ST_PAUSE;
                    end
                end
                ST_UPDATE: begin
                    if (hit_req) pending_q <= 1'b1;
                    if (slot_valid[idx_q]) begin
                        if (adv_y_c > ESC_LIM) begin
                            slot_valid[idx_q] <= 1'b0;
                            miss              <= 1'b1;
                        end else begin
                            slot_y[slot_lo(32'(idx_q)) +: Y_W] <= adv_y_c[Y_W-1:0];
                        end
                    end
                    if (idx_q == IDX_W'(NSLOT - 1)) begin
                        st_q <= ST_RUN;
                        busy <= 1'b0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (!pause) st_q <= ST_RUN;
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arrow_lane_ctrl.sv
// Directed test-plan steps plus a random phase, checked against a behavioural lane model.
module tb_arrow_lane_ctrl;

    localparam int NSLOT  = 4;
    localparam int BORDER = 350;
    localparam int WIN    = 10;
    localparam int SPEED  = 2;
    localparam int LO     = BORDER - WIN;
    localparam int HI     = BORDER + WIN;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, pause = 1'b0, frame_tick = 1'b0, spawn_req = 1'b0, hit_req = 1'b0;
    logic        spawn_ack, hit, miss, busy;
    logic [3:0]  slot_valid;
    logic [39:0] slot_y;
    logic [15:0] score;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    // Model: 0 idle, 1 run, 2 update, 3 pause
    int mst, midx, msc;
    bit mpend;
    bit mv[NSLOT];
    int my[NSLOT];
    bit e_ack, e_hit, e_miss;

    always #5 clk = ~clk;

    arrow_lane_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .frame_tick (frame_tick),
        .spawn_req  (spawn_req),
        .spawn_ack  (spawn_ack),
        .hit_req    (hit_req),
        .hit        (hit),
        .miss       (miss),
        .busy       (busy),
        .slot_valid (slot_valid),
        .slot_y     (slot_y),
        .score      (score),
        .state      (state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit fr[NSLOT];
        int best, fi;
        e_ack = 0; e_hit = 0; e_miss = 0;
        if (!rst) begin
            mst = 0; midx = 0; msc = 0; mpend = 0;
            for (int i = 0; i < NSLOT; i++) begin mv[i] = 0; my[i] = 0; end
        end else begin
            case (mst)
                0: begin
                    for (int i = 0; i < NSLOT; i++) mv[i] = 0;
                    if (start) begin msc = 0; mst = 1; end
                end
                1: begin
                    fr = mv;
                    if (hit_req || mpend) begin
                        mpend = 0;
                        best = -1;
                        for (int i = 0; i < NSLOT; i++)
                            if (mv[i] && my[i] >= LO && my[i] <= HI && (best < 0 || my[i] > my[best]))
                                best = i;
                        if (best >= 0) begin
                            mv[best] = 0; e_hit = 1;
                            if (msc < 65535) msc++;
                        end else e_miss = 1;
                    end
                    if (spawn_req) begin
                        fi = -1;
                        for (int i = 0; i < NSLOT; i++) if (!fr[i] && fi < 0) fi = i;
                        if (fi >= 0) begin mv[fi] = 1; my[fi] = 0; e_ack = 1; end
                    end
                    if (frame_tick) begin mst = 2; midx = 0; end
                    else if (pause) mst = 3;
                end
                2: begin
                    if (hit_req) mpend = 1;
                    if (mv[midx]) begin
                        if (my[midx] + SPEED > HI) begin mv[midx] = 0; e_miss = 1; end
                        else my[midx] = my[midx] + SPEED;
                    end
                    if (midx == NSLOT - 1) mst = 1; else midx++;
                end
                default: if (!pause) mst = 1;
            endcase
        end
    endtask

    task automatic compare_all();
        logic [39:0] ey, mask;
        logic [3:0]  ev;
        ey = '0; mask = '0; ev = '0;
        for (int i = 0; i < NSLOT; i++) begin
            ev[i] = mv[i];
            if (mv[i]) begin
                ey[i*10 +: 10]   = 10'(my[i]);
                mask[i*10 +: 10] = '1;
            end
        end
        chk("state", 64'(state), 64'(mst));
        chk("busy", 64'(busy), 64'(mst == 2));
        chk("spawn_ack", 64'(spawn_ack), 64'(e_ack));
        chk("hit", 64'(hit), 64'(e_hit));
        chk("miss", 64'(miss), 64'(e_miss));
        chk("score", 64'(score), 64'(msc));
        chk("slot_valid", 64'(slot_valid), 64'(ev));
        chk("slot_y", 64'(slot_y & mask), 64'(ey));
    endtask

    task automatic cyc(input bit r, input bit st, input bit pz, input bit tk, input bit sp, input bit hr);
        rst = r; start = st; pause = pz; frame_tick = tk; spawn_req = sp; hit_req = hr;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1, 0, 0, 1, 0, 0);
            idle(NSLOT);
        end
    endtask

    task automatic restart();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        int busy_n, hit_n;
        bit pz_lvl;
        logic [39:0] frozen;

        // 1: reset, start, spawn
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_valid", 64'(slot_valid), 64'd0);
        chk("rst_y", 64'(slot_y), 64'd0);
        chk("rst_pulses", 64'({spawn_ack, hit, miss, busy}), 64'd0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("t1_run", 64'(state), 64'd1);
        cyc(1, 0, 0, 0, 1, 0);
        chk("t1_ack", 64'(spawn_ack), 64'd1);
        chk("t1_valid", 64'(slot_valid), 64'b0001);
        chk("t1_y", 64'(slot_y[9:0]), 64'd0);
        chk("t1_score", 64'(score), 64'd0);

        // 2: 170 frames then a hit
        ticks(170);
        chk("t2_y", 64'(slot_y[9:0]), 64'd340);
        cyc(1, 0, 0, 0, 0, 1);
        chk("t2_hit", 64'(hit), 64'd1);
        chk("t2_valid", 64'(slot_valid), 64'd0);
        chk("t2_score", 64'(score), 64'd1);
        idle(1);
        chk("t2_hit_once", 64'(hit), 64'd0);

        // 3: arrow escapes on the 181st frame
        restart();
        cyc(1, 0, 0, 0, 1, 0);
        ticks(180);
        chk("t3_y", 64'(slot_y[9:0]), 64'd360);
        chk("t3_valid", 64'(slot_valid), 64'b0001);
        cyc(1, 0, 0, 1, 0, 0);
        idle(1);
        chk("t3_miss", 64'(miss), 64'd1);
        chk("t3_cleared", 64'(slot_valid), 64'd0);
        idle(3);

        // 4: two arrows in window, largest y wins, then empty press
        restart();
        cyc(1, 0, 0, 0, 1, 0);
        ticks(7);
        cyc(1, 0, 0, 0, 1, 0);
        ticks(171);
        chk("t4_y0", 64'(slot_y[9:0]), 64'd356);
        chk("t4_y1", 64'(slot_y[19:10]), 64'd342);
        cyc(1, 0, 0, 0, 0, 1);
        chk("t4_hit1", 64'(hit), 64'd1);
        chk("t4_valid1", 64'(slot_valid), 64'b0010);
        ticks(1);
        chk("t4_y1_adv", 64'(slot_y[19:10]), 64'd344);
        cyc(1, 0, 0, 0, 0, 1);
        chk("t4_score", 64'(score), 64'd2);
        cyc(1, 0, 0, 0, 0, 1);
        chk("t4_empty_miss", 64'({hit, miss}), 64'b01);

        // 5: hit during UPDATE is deferred to the first RUN cycle
        restart();
        cyc(1, 0, 0, 0, 1, 0);
        ticks(175);
        busy_n = 0; hit_n = 0;
        cyc(1, 0, 0, 1, 0, 0);
        busy_n += int'(busy); hit_n += int'(hit);
        cyc(1, 0, 0, 0, 0, 1);
        busy_n += int'(busy); hit_n += int'(hit);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            busy_n += int'(busy); hit_n += int'(hit);
        end
        chk("t5_no_early_hit", 64'(hit_n), 64'd0);
        idle(1);
        busy_n += int'(busy);
        chk("t5_hit", 64'(hit), 64'd1);
        chk("t5_busy_cycles", 64'(busy_n), 64'd4);

        // 6: full pool, slot reuse, pause freeze, reset in PAUSE
        restart();
        cyc(1, 0, 0, 0, 1, 0);
        ticks(170);
        repeat (3) cyc(1, 0, 0, 0, 1, 0);
        chk("t6_full", 64'(slot_valid), 64'hF);
        cyc(1, 0, 0, 0, 1, 0);
        chk("t6_no_ack", 64'(spawn_ack), 64'd0);
        cyc(1, 0, 0, 0, 1, 1);
        chk("t6_hit_no_ack", 64'({hit, spawn_ack}), 64'b10);
        cyc(1, 0, 0, 0, 1, 0);
        chk("t6_reuse_ack", 64'(spawn_ack), 64'd1);
        chk("t6_reuse_slot", 64'(slot_valid), 64'hF);
        ticks(3);
        cyc(1, 0, 1, 0, 0, 0);
        chk("t6_pause", 64'(state), 64'd3);
        repeat (10) cyc(1, 0, 1, 1, 0, 0);
        frozen = {4{10'd6}};
        chk("t6_frozen", 64'(slot_y), 64'(frozen));
        cyc(0, 0, 1, 0, 0, 0);
        chk("t6_rst_state", 64'(state), 64'd0);
        chk("t6_rst_out", 64'({spawn_ack, hit, miss, busy, slot_valid}), 64'd0);
        chk("t6_rst_y", 64'(slot_y), 64'd0);
        chk("t6_rst_score", 64'(score), 64'd0);

        // Random phase
        pz_lvl = 0;
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 29) == 0) pz_lvl = !pz_lvl;
            cyc($urandom_range(0, 499) != 0, $urandom_range(0, 39) == 0, pz_lvl,
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
